ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/ex_mem_skid.sv | 43 ++++
 rtl/ex_mem_stage.sv | 76 +++++++
 tb/tb_ex_mem_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU control codes, payload widths and the EX/MEM payload layout
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int REG_W = 5;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;
  localparam logic [3:0] ALU_CTRL_MAX = 4'b1001;
  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             carry;
    logic             overflow;
    logic             branch_taken;
    logic             illegal;
  } ex_mem_t;
  function automatic logic is_illegal(input logic [3:0] ctrl);
    return ctrl > ALU_CTRL_MAX;
  endfunction
  function automatic logic has_flags(input logic [3:0] ctrl);
    return ctrl == ALU_ADD || ctrl == ALU_SUB;
  endfunction
endpackage

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry elastic buffer (main + skid) with registered in_ready
module ex_mem_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         accept, drain;
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = ~main_valid | out_ready;
  // main refills from skid first to keep order; skid only captures while main is held
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      main_valid <= skid_valid | accept;
      skid_valid <= skid_valid & accept;
      if (skid_valid) main_data <= skid_data;
      else if (accept) main_data <= in_data;
      if (skid_valid & accept) skid_data <= in_data;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch, illegal-op and flag masking
module ex_mem_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_ctrl,
  input  logic [XLEN-1:0]  in_result,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic [XLEN-1:0]  in_store_data,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_mem_to_reg,
  input  logic             in_branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [XLEN-1:0]  out_store_data,
  output logic [REG_W-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_branch_taken,
  output logic             out_illegal
);
  ex_mem_t in_pl, out_pl;
  logic    ill, flg;
  // pack the entry, masking side effects of illegal ops and flags of non-arithmetic ops
  always_comb begin
    ill                = is_illegal(in_alu_ctrl);
    flg                = has_flags(in_alu_ctrl);
    in_pl.result       = in_result;
    in_pl.store_data   = in_store_data;
    in_pl.rd           = in_rd;
    in_pl.reg_write    = in_reg_write & ~ill;
    in_pl.mem_read     = in_mem_read & ~ill;
    in_pl.mem_write    = in_mem_write & ~ill;
    in_pl.mem_to_reg   = in_mem_to_reg;
    in_pl.carry        = in_carry & flg;
    in_pl.overflow     = in_overflow & flg;
    in_pl.branch_taken = in_branch & in_zero;
    in_pl.illegal      = ill;
  end
  ex_mem_skid #(.W($bits(ex_mem_t))) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );
  assign out_result       = out_pl.result;
  assign out_store_data   = out_pl.store_data;
  assign out_rd           = out_pl.rd;
  assign out_reg_write    = out_pl.reg_write;
  assign out_mem_read     = out_pl.mem_read;
  assign out_mem_write    = out_pl.mem_write;
  assign out_mem_to_reg   = out_pl.mem_to_reg;
  assign out_carry        = out_pl.carry;
  assign out_overflow     = out_pl.overflow;
  assign out_branch_taken = out_pl.branch_taken;
  assign out_illegal      = out_pl.illegal;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and random checks of ex_mem_stage against a queue model
module tb_ex_mem_stage;
  logic clk = 1'b0, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_alu_ctrl;
  logic [63:0] in_result, in_store_data, out_result, out_store_data;
  logic [4:0] in_rd, out_rd;
  logic in_zero, in_carry, in_overflow, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch;
  logic out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_carry, out_overflow, out_branch_taken, out_illegal;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [63:0] result, store;
    logic [4:0] rd;
    logic rw, mr, mw, m2r, c, o, bt, il;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctrl(in_alu_ctrl), .in_result(in_result), .in_zero(in_zero), .in_carry(in_carry),
    .in_overflow(in_overflow), .in_store_data(in_store_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_branch(in_branch), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_of();
    exp_t e;
    logic ill = in_alu_ctrl >= 4'd10;
    logic arith = in_alu_ctrl == 4'd2 || in_alu_ctrl == 4'd6;
    e.result = in_result;
    e.store = in_store_data;
    e.rd = in_rd;
    e.rw = ill ? 1'b0 : in_reg_write;
    e.mr = ill ? 1'b0 : in_mem_read;
    e.mw = ill ? 1'b0 : in_mem_write;
    e.m2r = in_mem_to_reg;
    e.c = arith ? in_carry : 1'b0;
    e.o = arith ? in_overflow : 1'b0;
    e.bt = in_branch && in_zero;
    e.il = ill;
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("result", out_result, q[0].result);
      chk("store_data", out_store_data, q[0].store);
      chk("rd", out_rd, q[0].rd);
      chk("reg_write", out_reg_write, q[0].rw);
      chk("mem_read", out_mem_read, q[0].mr);
      chk("mem_write", out_mem_write, q[0].mw);
      chk("mem_to_reg", out_mem_to_reg, q[0].m2r);
      chk("carry", out_carry, q[0].c);
      chk("overflow", out_overflow, q[0].o);
      chk("branch_taken", out_branch_taken, q[0].bt);
      chk("illegal", out_illegal, q[0].il);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_result"}, out_result, 0);
    chk({tag, "_store"}, out_store_data, 0);
    chk({tag, "_flags"}, {out_rd, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                          out_carry, out_overflow, out_branch_taken, out_illegal}, 0);
  endtask

  task automatic step();
    exp_t e = expect_of();
    logic acc = in_valid && q.size() < 2 && !flush;
    logic pop = q.size() > 0 && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_in();
    in_alu_ctrl = 4'($urandom_range(0, 15));
    in_result = {$urandom, $urandom};
    in_store_data = {$urandom, $urandom};
    in_rd = 5'($urandom);
    {in_zero, in_carry, in_overflow, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch} = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_in();
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    rand_in(); in_alu_ctrl = 4'b0010; in_result = 64'd5; in_zero = 1'b0; in_branch = 1'b0;
    step();
    chk("stream_a", out_result, 64'd5);
    rand_in(); in_alu_ctrl = 4'b0110; in_result = 64'd0; in_zero = 1'b1; in_branch = 1'b1;
    step();
    chk("stream_b_branch", out_branch_taken, 1);
    rand_in(); in_alu_ctrl = 4'b0011; in_result = 64'hFF;
    step();
    chk("stream_c", out_result, 64'hFF);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step();
    end
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step();
    end
    in_valid = 1'b0;
    step(); step();
    rand_in(); in_valid = 1'b1; in_alu_ctrl = 4'b1011; in_reg_write = 1'b1;
    step();
    chk("illegal_flag", out_illegal, 1);
    chk("illegal_rw", out_reg_write, 0);
    rand_in(); in_alu_ctrl = 4'b0000; in_carry = 1'b1; in_overflow = 1'b1;
    step();
    chk("and_carry", out_carry, 0);
    chk("and_overflow", out_overflow, 0);
    out_ready = 1'b0;
    rand_in(); step();
    rand_in(); step();
    chk("pre_flush_full", in_ready, 0);
    flush = 1'b1; rand_in();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    in_valid = 1'b1;
    rand_in(); step();
    rand_in(); step();
    #1 reset = 1'b1;
    #1 chk_zero("async_reset");
    q.delete();
    #1 reset = 1'b0;
    rand_in(); in_valid = 1'b1;
    step();
    chk("resume", out_valid, 1);
    for (int i = 0; i < 400; i++) begin
      rand_in();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
